// File: rtl/scratchpad_phase_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_phase_sequencer_pkg
// Brief    : Shared state encoding and width helpers for the phase sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package scratchpad_phase_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_FIN    = 3'd4
    } seq_state_e;

    function automatic int ph_width(input int num_phases);
        return (num_phases > 1) ? $clog2(num_phases) : 1;
    endfunction

    // Counter wide enough to hold max_count itself, never narrower than 1 bit.
    function automatic int cnt_width(input int max_count);
        return (max_count > 0) ? $clog2(max_count + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scratchpad_phase_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_phase_sequencer_if
// Brief    : Control, engine-side and scratchpad-side bundle of the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface scratchpad_phase_sequencer_if
    import scratchpad_phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES = 2,
    parameter int ADDR_W     = 16,
    parameter int WDATA_W    = 128,
    parameter int PH_W       = ph_width(NUM_PHASES)
) ();

    logic                          start;
    logic                          abort;
    logic [NUM_PHASES-1:0]         phase_start;
    logic [NUM_PHASES-1:0]         phase_done;
    logic [NUM_PHASES*ADDR_W-1:0]  ph_rd_addr;
    logic [NUM_PHASES*ADDR_W-1:0]  ph_wr_addr;
    logic [NUM_PHASES*WDATA_W-1:0] ph_wr_data;
    logic [NUM_PHASES-1:0]         ph_we;
    logic [ADDR_W-1:0]             mem_rd_addr;
    logic [ADDR_W-1:0]             mem_wr_addr;
    logic [WDATA_W-1:0]            mem_wr_data;
    logic                          mem_we;
    logic [PH_W-1:0]               active_phase;
    logic                          busy;
    logic                          done;
    logic                          err_timeout;

    modport master (
        input  start, abort, phase_done, ph_rd_addr, ph_wr_addr, ph_wr_data, ph_we,
        output phase_start, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_we,
               active_phase, busy, done, err_timeout
    );

    modport slave (
        output start, abort, phase_done, ph_rd_addr, ph_wr_addr, ph_wr_data, ph_we,
        input  phase_start, mem_rd_addr, mem_wr_addr, mem_wr_data, mem_we,
               active_phase, busy, done, err_timeout
    );

endinterface
`default_nettype wire

// File: rtl/scratchpad_phase_sequencer_sp_port_mux.sv
`default_nettype none
// ============================================================================
// Module   : sp_port_mux
// Brief    : NUM_PHASES-way select of one engine's scratchpad port by index.
// Revision : 1.0 - initial release
// ============================================================================
module sp_port_mux #(
    parameter int NUM_PHASES = 2,
    parameter int ADDR_W     = 16,
    parameter int WDATA_W    = 128,
    parameter int PH_W       = 1
) (
    input  wire logic [PH_W-1:0]               sel_i,
    input  wire logic [NUM_PHASES*ADDR_W-1:0]  rd_addr_i,
    input  wire logic [NUM_PHASES*ADDR_W-1:0]  wr_addr_i,
    input  wire logic [NUM_PHASES*WDATA_W-1:0] wr_data_i,
    input  wire logic [NUM_PHASES-1:0]         we_i,
    output logic      [ADDR_W-1:0]             rd_addr_o,
    output logic      [ADDR_W-1:0]             wr_addr_o,
    output logic      [WDATA_W-1:0]            wr_data_o,
    output logic                               we_o
);

    // Engine 0 is the fallback, so unused index codes never produce X.
    always_comb begin
        rd_addr_o = rd_addr_i[ADDR_W-1:0];
        wr_addr_o = wr_addr_i[ADDR_W-1:0];
        wr_data_o = wr_data_i[WDATA_W-1:0];
        we_o      = we_i[0];
        for (int i = 1; i < NUM_PHASES; i++) begin
            if (sel_i == PH_W'(i)) begin
                rd_addr_o = rd_addr_i[i*ADDR_W +: ADDR_W];
                wr_addr_o = wr_addr_i[i*ADDR_W +: ADDR_W];
                wr_data_o = wr_data_i[i*WDATA_W +: WDATA_W];
                we_o      = we_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/scratchpad_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : scratchpad_phase_sequencer
// Brief    : Runs NUM_PHASES engines in order, granting each the scratchpad port.
// Revision : 1.0 - initial release
// ============================================================================
module scratchpad_phase_sequencer
    import scratchpad_phase_sequencer_pkg::*;
#(
    parameter int NUM_PHASES   = 2,
    parameter int ADDR_W       = 16,
    parameter int WDATA_W      = 128,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 0,
    parameter int PH_W         = ph_width(NUM_PHASES)
) (
    input wire logic                     clock,
    input wire logic                     rst_n,
    scratchpad_phase_sequencer_if.master bus
);

    localparam int DCNT_W = cnt_width(DRAIN_CYCLES);
    localparam int WCNT_W = cnt_width(TIMEOUT);

    seq_state_e        state_q, state_d;
    logic [PH_W-1:0]   idx_q, idx_d;
    logic [DCNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic [WCNT_W-1:0] wd_cnt_q, wd_cnt_d;
    logic              err_q, err_d;

    logic              w_done_sel;
    logic              w_we_sel;
    logic              w_last;
    seq_state_e        w_adv_state;
    logic [PH_W-1:0]   w_adv_idx;

    sp_port_mux #(
        .NUM_PHASES (NUM_PHASES),
        .ADDR_W     (ADDR_W),
        .WDATA_W    (WDATA_W),
        .PH_W       (PH_W)
    ) u_port_mux (
        .sel_i      (idx_q),
        .rd_addr_i  (bus.ph_rd_addr),
        .wr_addr_i  (bus.ph_wr_addr),
        .wr_data_i  (bus.ph_wr_data),
        .we_i       (bus.ph_we),
        .rd_addr_o  (bus.mem_rd_addr),
        .wr_addr_o  (bus.mem_wr_addr),
        .wr_data_o  (bus.mem_wr_data),
        .we_o       (w_we_sel)
    );

    always_comb begin
        w_done_sel = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (idx_q == PH_W'(i)) begin
                w_done_sel = bus.phase_done[i];
            end
        end
    end

    // Where a finished phase goes once its drain window (if any) is over.
    always_comb begin
        w_last      = (idx_q == PH_W'(NUM_PHASES - 1));
        w_adv_state = w_last ? ST_FIN : ST_LAUNCH;
        w_adv_idx   = w_last ? idx_q : idx_q + 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            drain_cnt_q <= '0;
            wd_cnt_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            drain_cnt_q <= drain_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        drain_cnt_d = drain_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                wd_cnt_d    = '0;
                drain_cnt_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                // A done in the expiry cycle still counts as completion.
                if (w_done_sel) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = w_adv_state;
                        idx_d   = w_adv_idx;
                    end else begin
                        drain_cnt_d = '0;
                        state_d     = ST_DRAIN;
                    end
                end else if (TIMEOUT > 0) begin
                    if (wd_cnt_q == WCNT_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DCNT_W'(DRAIN_CYCLES - 1)) begin
                    state_d = w_adv_state;
                    idx_d   = w_adv_idx;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            err_d   = err_q;
        end
    end

    always_comb begin
        bus.phase_start = '0;
        if (state_q == ST_LAUNCH) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                bus.phase_start[i] = (idx_q == PH_W'(i));
            end
        end
        // Abort cuts the write strobe in the same cycle, ahead of the state change.
        bus.mem_we       = w_we_sel && !bus.abort &&
                           ((state_q == ST_LAUNCH) || (state_q == ST_RUN) ||
                            (state_q == ST_DRAIN));
        bus.done         = (state_q == ST_FIN) && !bus.abort;
        bus.busy         = (state_q != ST_IDLE);
        bus.active_phase = idx_q;
        bus.err_timeout  = err_q;
    end

endmodule
`default_nettype wire
